ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Single-port RAM arbiter between the Mini SRC CPU memory path (MAR/MDR) and a debug/program-loader port. It sits between the CPU and the synchronous 512x32 RAM, serialises all accesses through a three-state sequencer, and guarantees the loader forward progress with a bounded-wait fairness rule. A lock input lets the loader own memory outright while the CPU is halted.

## Interface
- ADDR_W, 9: RAM address width (512 words).
- DATA_W, 32: data width.
- MAX_WAIT, 4: consecutive lost arbitrations after which the loader wins a tie.
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- cpu_req / dbg_req  in  1  access request, level; sampled only in IDLE.
- cpu_we / dbg_we  in  1  1 = write, 0 = read.
- cpu_addr / dbg_addr  in  ADDR_W  word address.
- cpu_wdata / dbg_wdata  in  DATA_W  write data.
- cpu_ack / dbg_ack  out  1  one-cycle completion pulse.
- cpu_rdata / dbg_rdata  out  DATA_W  read data, registered, valid with ack and held until the next read by that port.
- dbg_lock  in  1  when high, the CPU is never granted.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data, valid one edge after address capture.
- owner  out  1  0 = CPU, 1 = loader; the current or most recent grant.
- busy  out  1  high in ACCESS and RESP.

## Operation
- States: IDLE -> ACCESS -> RESP -> IDLE. One access completes every 3 cycles.
- **IDLE:**
  - If any eligible req is high, pick the winner, latch its we/addr/wdata and set owner.
  - Go to ACCESS; otherwise stay in IDLE.
- **Winner selection:**
  - CPU eligible only if dbg_lock = 0.
  - Only one eligible requester: it wins.
  - Both eligible: CPU wins unless wait_cnt == MAX_WAIT, in which case the loader wins.
- **wait_cnt:**
  - Increments (saturating at MAX_WAIT) when the loader requests in IDLE and loses.
  - Clears when the loader is granted or dbg_req is low in IDLE.
- **ACCESS:**
  - ram_addr and ram_data are driven from the latched registers.
  - ram_wren = latched_we & ~Reset.
  - The RAM captures at the closing edge; go to RESP.
- **RESP:**
  - ram_wren = 0.
  - At the closing edge, assert the owner's ack for one cycle.
  - If the access was a read, load ram_q into that owner's rdata.
  - Go to IDLE.
- The ack cycle coincides with IDLE.
  - A req still high in that cycle is arbitrated as a new transaction using the command fields present then.
  - A requester wanting a single access must drop req during its ack cycle.
- Command inputs are ignored outside IDLE; changing them mid-access has no effect.
- The non-owner's ack and rdata never change.
- Reset values:
  - State IDLE, wait_cnt 0.
  - cpu_ack = dbg_ack = 0, cpu_rdata = dbg_rdata = 0.
  - ram_addr = ram_data = 0, ram_wren = 0, owner = 0, busy = 0.

## Timing
- Request sampled at edge E0. RAM captures at E1. ack and rdata are visible after E2 for exactly one cycle. Latency from sampling edge to ack is 2 edges.
- Reset during ACCESS: ram_wren is forced low that cycle, so no write commits. State returns to IDLE with no ack.
- Reset during RESP: no ack and no rdata update.
- Reset asserted together with req: req is ignored until the first IDLE cycle after Reset deasserts.
- dbg_lock rising while the CPU owns ACCESS/RESP: the CPU access completes normally, and the lock applies from the next IDLE.
- Both requesting continuously with dbg_lock = 0: the loader is granted on every (MAX_WAIT+1)th arbitration.
- wait_cnt saturates at MAX_WAIT and never wraps.

## Structure
- Shared package (`ram_arbiter_pkg`):
  - State enum: ARB_IDLE, ARB_ACCESS, ARB_RESP.
  - Owner constants: OWN_CPU = 0, OWN_DBG = 1.
  - Default widths ADDR_W = 9, DATA_W = 32.
- One sub-module, `ram_arb_fairness`: wait_cnt, saturation, and the combinational winner decision (inputs cpu_req, dbg_req, dbg_lock, arb_en). The top level holds the FSM, command latches and rdata registers.

## Test plan
- CPU write 0x1234_5678 @0x020, then CPU read @0x020 -> cpu_ack pulses 2 edges after each sample; cpu_rdata = 0x1234_5678; dbg_ack stays 0.
- Both requesters held high, MAX_WAIT = 4, 20 arbitrations -> grant order CCCCD repeating; loader gets exactly 4 grants.
- dbg_lock = 1, both requesting -> only the loader is granted; a CPU request pending 10 accesses gets no ack until lock drops, then is granted at the next IDLE.
- Loader write 0xDEAD_BEEF @0x1FF with Reset pulsed in its ACCESS cycle; then read @0x1FF -> the old contents are returned (no write); no ack for the aborted access.
- Single CPU read with req dropped in the ack cycle -> exactly one ack and busy high for 2 cycles. With req held, a second access starts in the ack cycle and acks 3 cycles after the first.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and default parameters for the Mini SRC RAM arbiter.
package ram_arbiter_pkg;

    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/ram_arb_fairness.sv
// Winner selection between CPU and loader, with a saturating loss counter that
// lets the loader win a tie after MAX_WAIT consecutive losses.
module ram_arb_fairness
    import ram_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = ram_arbiter_pkg::MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic dbg_lock,
    input  logic arb_en,
    output logic grant_valid,
    output logic grant_owner
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              cpu_elig;

    always_comb begin
        cpu_elig    = cpu_req & ~dbg_lock;
        grant_valid = arb_en & (cpu_elig | dbg_req);

        if (cpu_elig && dbg_req) begin
            grant_owner = (wait_cnt_q == WAIT_MAX) ? OWN_DBG : OWN_CPU;
        end else begin
            grant_owner = dbg_req ? OWN_DBG : OWN_CPU;
        end

        // Counter only moves on arbitration cycles; it never wraps past MAX_WAIT.
        wait_cnt_d = wait_cnt_q;
        if (arb_en) begin
            if (!dbg_req || grant_owner == OWN_DBG) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: serialises CPU and loader accesses to a synchronous
// RAM through an IDLE -> ACCESS -> RESP sequencer.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ram_arbiter_pkg::ADDR_W,
    parameter int DATA_W   = ram_arbiter_pkg::DATA_W,
    parameter int MAX_WAIT = ram_arbiter_pkg::MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              owner,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic arb_en;
    logic grant_valid;
    logic grant_owner;

    assign arb_en = (state_q == ARB_IDLE);

    ram_arb_fairness #(
        .MAX_WAIT(MAX_WAIT)
    ) u_fairness (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .dbg_lock   (dbg_lock),
        .arb_en     (arb_en),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    always_comb begin
        // NOTE: every _d starts from its hold value so no branch of the case infers a latch.
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    if (grant_owner == OWN_DBG) begin
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                // Only the owner's ack/rdata move; the other port is left untouched.
                if (owner_q == OWN_DBG) begin
                    dbg_ack_d = 1'b1;
                    if (!we_q) dbg_rdata_d = ram_q;
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!we_q) cpu_rdata_d = ram_q;
                end
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment; blocking stays in always_comb.
        if (rst) begin
            state_q     <= ARB_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= OWN_CPU;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Reset gates the write strobe combinationally so an aborted ACCESS never commits.
    assign ram_wren  = (state_q == ARB_ACCESS) & we_q & ~rst;
    assign ram_addr  = addr_q;
    assign ram_data  = wdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != ARB_IDLE);
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_ram_arbiter;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int WORDS = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_lock = 1'b0;
    logic          cpu_ack, dbg_ack;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q = '0;
    logic          owner, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_WAIT(MW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .dbg_req  (dbg_req),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack  (dbg_ack),
        .dbg_rdata(dbg_rdata),
        .dbg_lock (dbg_lock),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .owner    (owner),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Synchronous 512x32 RAM: captures address (and write) at the edge, q one edge later.
    logic [DW-1:0] ram_mem [WORDS];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    // Reference model: one transaction in flight, described by cycles remaining
    // (0 = free, 2 = RAM access this cycle, 1 = response this cycle).
    logic [DW-1:0] ref_mem [WORDS];
    int            m_left = 0;
    int            m_streak = 0;
    logic          m_owner = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_cpu_ack = 1'b0, m_dbg_ack = 1'b0;
    logic [DW-1:0] m_cpu_rdata = '0, m_dbg_rdata = '0;

    always @(posedge clk) begin : ref_model
        bit cpu_ok;
        bit dbg_wins;
        if (rst) begin
            m_left      = 0;
            m_streak    = 0;
            m_owner     = 1'b0;
            m_cpu_ack   = 1'b0;
            m_dbg_ack   = 1'b0;
            m_cpu_rdata = '0;
            m_dbg_rdata = '0;
        end else begin
            m_cpu_ack = 1'b0;
            m_dbg_ack = 1'b0;
            if (m_left == 0) begin
                cpu_ok   = cpu_req && !dbg_lock;
                dbg_wins = (cpu_ok && dbg_req) ? (m_streak >= MW) : dbg_req;
                if (dbg_req && !dbg_wins) m_streak = (m_streak < MW) ? m_streak + 1 : MW;
                else                      m_streak = 0;
                if (cpu_ok || dbg_req) begin
                    m_owner = dbg_wins;
                    m_we    = dbg_wins ? dbg_we    : cpu_we;
                    m_addr  = dbg_wins ? dbg_addr  : cpu_addr;
                    m_wdata = dbg_wins ? dbg_wdata : cpu_wdata;
                    m_left  = 2;
                end
            end else if (m_left == 2) begin
                if (m_we) ref_mem[m_addr] = m_wdata;
                m_left = 1;
            end else begin
                if (m_owner) begin
                    m_dbg_ack = 1'b1;
                    if (!m_we) m_dbg_rdata = ref_mem[m_addr];
                end else begin
                    m_cpu_ack = 1'b1;
                    if (!m_we) m_cpu_rdata = ref_mem[m_addr];
                end
                m_left = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always begin
        @(posedge clk);
        #1;
        check("cpu_ack",   64'(cpu_ack),   64'(m_cpu_ack));
        check("dbg_ack",   64'(dbg_ack),   64'(m_dbg_ack));
        check("cpu_rdata", 64'(cpu_rdata), 64'(m_cpu_rdata));
        check("dbg_rdata", 64'(dbg_rdata), 64'(m_dbg_rdata));
        check("owner",     64'(owner),     64'(m_owner));
        check("busy",      64'(busy),      64'(m_left != 0));
        check("ram_wren",  64'(ram_wren),  64'((m_left == 2) && m_we && !rst));
        if (m_left == 2) begin
            check("ram_addr", 64'(ram_addr), 64'(m_addr));
            if (m_we) check("ram_data", 64'(ram_data), 64'(m_wdata));
        end
    end

    // Single access from an idle arbiter; lat = edges after the sampling edge until ack.
    task automatic access(input bit is_dbg, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output int lat);
        @(negedge clk);
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        end
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (is_dbg ? dbg_ack : cpu_ack) break;
        end
    endtask

    initial begin
        int            lat;
        int            n_cpu, n_dbg, k, n_ack, n_busy, first, second;
        logic [DW-1:0] old_val;

        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end

        repeat (3) @(negedge clk);
        check("rst_busy",     64'(busy),      64'd0);
        check("rst_owner",    64'(owner),     64'd0);
        check("rst_wren",     64'(ram_wren),  64'd0);
        check("rst_ram_addr", 64'(ram_addr),  64'd0);
        check("rst_ram_data", 64'(ram_data),  64'd0);
        check("rst_cpu_rd",   64'(cpu_rdata), 64'd0);
        check("rst_dbg_rd",   64'(dbg_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // CPU write then read back.
        access(1'b0, 1'b1, 9'h020, 32'h1234_5678, lat);
        check("wr_latency", 64'(lat), 64'd2);
        access(1'b0, 1'b0, 9'h020, 32'h0, lat);
        check("rd_latency", 64'(lat), 64'd2);
        check("rd_data",    64'(cpu_rdata), 64'h1234_5678);

        // Lock: only the loader is served while dbg_lock is high.
        @(negedge clk);
        dbg_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h020;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h006;
        n_cpu = 0;
        n_dbg = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ack) n_cpu++;
            if (dbg_ack) n_dbg++;
            if (n_dbg == 10) break;
        end
        check("lock_dbg_grants", 64'(n_dbg), 64'd10);
        check("lock_cpu_grants", 64'(n_cpu), 64'd0);
        @(negedge clk);
        dbg_lock = 1'b0;
        dbg_req  = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_ack) break;
        end
        check("unlock_cpu_latency", 64'(lat), 64'd3);
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        // Fairness: both held high, loader wins every fifth arbitration.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h011;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h012;
        k = 0;
        n_dbg = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ack || dbg_ack) begin
                k++;
                check($sformatf("order_%0d_is_dbg", k), 64'(dbg_ack), 64'(k % 5 == 0));
                if (dbg_ack) n_dbg++;
                if (k == 20) break;
            end
        end
        @(negedge clk);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("fair_arbitrations", 64'(k),     64'd20);
        check("fair_dbg_grants",   64'(n_dbg), 64'd4);
        repeat (3) @(negedge clk);

        // Reset in the ACCESS cycle of a loader write: nothing commits, no ack.
        access(1'b1, 1'b1, 9'h1FF, 32'hCAFE_F00D, lat);
        old_val = 32'hCAFE_F00D;
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h1FF; dbg_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        dbg_req = 1'b0;
        rst     = 1'b1;
        #1;
        check("abort_wren", 64'(ram_wren), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_ack = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            n_ack += int'(cpu_ack) + int'(dbg_ack);
        end
        check("abort_no_ack", 64'(n_ack), 64'd0);
        access(1'b1, 1'b0, 9'h1FF, 32'h0, lat);
        check("abort_rd_latency", 64'(lat),       64'd2);
        check("abort_old_data",   64'(dbg_rdata), 64'(old_val));

        // Single CPU read, req dropped in the ack cycle.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h020;
        n_ack  = 0;
        n_busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            n_busy += int'(busy);
            if (cpu_ack) begin
                n_ack++;
                @(negedge clk);
                cpu_req = 1'b0;
            end
        end
        check("single_acks", 64'(n_ack),     64'd1);
        check("single_busy", 64'(n_busy),    64'd2);
        check("single_data", 64'(cpu_rdata), 64'h1234_5678);

        // Req held: back-to-back accesses ack three cycles apart.
        @(negedge clk);
        cpu_req = 1'b1;
        first  = -1;
        second = -1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ack) begin
                if (first < 0)       first  = i;
                else if (second < 0) second = i;
            end
        end
        check("held_ack_gap", 64'(second - first), 64'd3);
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized traffic, including lock stretches and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            cpu_req   = ($urandom_range(0, 99) < 60);
            dbg_req   = ($urandom_range(0, 99) < 45);
            cpu_we    = 1'($urandom);
            dbg_we    = 1'($urandom);
            cpu_addr  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
            dbg_addr  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            dbg_wdata = $urandom;
            if ($urandom_range(0, 99) < 5) dbg_lock = ~dbg_lock;
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        cpu_req  = 1'b0;
        dbg_req  = 1'b0;
        dbg_lock = 1'b0;
        rst      = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
